// File: rtl/drink_vending_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | drink_vending_ctrl_if                                                      |
// | Coin-slot / dispenser / hopper signal bundle for drink_vending_ctrl.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface drink_vending_ctrl_if #(
  parameter int CW = 5
);
  logic [1:0]    X;
  logic          Cancel;
  logic          Vend_ack;
  logic [2:0]    cur_state;
  logic [CW-1:0] Credit;
  logic          Vend;
  logic          Change_pulse;
  logic          Coin_reject;
  logic          Busy;

  // master: coin decoder / dispenser side; slave: the controller
  modport master (
    output X, Cancel, Vend_ack,
    input  cur_state, Credit, Vend, Change_pulse, Coin_reject, Busy
  );

  modport slave (
    input  X, Cancel, Vend_ack,
    output cur_state, Credit, Vend, Change_pulse, Coin_reject, Busy
  );
endinterface
`default_nettype wire

// File: rtl/drink_vending_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | drink_vending_ctrl                                                         |
// | Three-coin drink vending FSM: credit accumulation, vend handshake,         |
// | serial change pay-out and cancel/refund.                                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module drink_vending_ctrl #(
  parameter int CW    = 5,
  parameter int PRICE = 3,
  parameter int V1    = 1,
  parameter int V2    = 2,
  parameter int V3    = 10
) (
  input  wire logic          CP_20ms,
  input  wire logic          Rst_sync,
  drink_vending_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_ACCUM  = 3'b001,
    ST_VEND   = 3'b010,
    ST_CHANGE = 3'b011,
    ST_REFUND = 3'b100
  } state_t;

  localparam logic [CW:0]   MAX_CREDIT = {1'b0, {CW{1'b1}}};
  localparam logic [CW:0]   PRICE_X    = (CW+1)'(PRICE);
  localparam logic [CW:0]   V1_X       = (CW+1)'(V1);
  localparam logic [CW:0]   V2_X       = (CW+1)'(V2);
  localparam logic [CW:0]   V3_X       = (CW+1)'(V3);
  localparam logic [CW-1:0] CREDIT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        r_state;
  logic [CW-1:0] r_credit;
  logic          r_vend;
  logic          r_change_pulse;
  logic          r_coin_reject;
  logic [1:0]    r_pre_x;

  state_t        w_state_nx;
  logic [CW-1:0] w_credit_nx;
  logic          w_vend_nx;
  logic          w_change_pulse_nx;
  logic          w_coin_reject_nx;

  logic          w_coin_evt;
  logic [CW:0]   w_coin_val;
  logic [CW:0]   w_sum;
  logic [CW:0]   w_rem;
  logic          w_overflow;
  logic          w_reach_price;
  logic          w_credit_nz;

  // Coin edge detection and the credit arithmetic, kept one bit wider than
  // the credit register so an overflowing coin can be detected and refused.
  always_comb begin
    w_coin_evt = (bus.X != 2'b00) && (bus.X != r_pre_x);
    case (bus.X)
      2'b01:   w_coin_val = V1_X;
      2'b10:   w_coin_val = V2_X;
      2'b11:   w_coin_val = V3_X;
      default: w_coin_val = '0;
    endcase
    w_sum         = {1'b0, r_credit} + w_coin_val;
    w_rem         = w_sum - PRICE_X;
    w_overflow    = (w_sum > MAX_CREDIT);
    w_reach_price = (w_sum >= PRICE_X);
    w_credit_nz   = (r_credit != '0);
  end

  always_comb begin
    w_state_nx        = r_state;
    w_credit_nx       = r_credit;
    w_vend_nx         = r_vend;
    w_change_pulse_nx = 1'b0;
    w_coin_reject_nx  = 1'b0;

    case (r_state)
      ST_IDLE, ST_ACCUM: begin
        if ((r_state == ST_ACCUM) && bus.Cancel) begin
          // Cancel beats a coincident coin, which goes back to the customer
          w_state_nx       = ST_REFUND;
          w_coin_reject_nx = w_coin_evt;
        end else if (w_coin_evt) begin
          if (w_overflow) begin
            w_coin_reject_nx = 1'b1;
          end else if (w_reach_price) begin
            w_credit_nx = w_rem[CW-1:0];
            w_vend_nx   = 1'b1;
            w_state_nx  = ST_VEND;
          end else begin
            w_credit_nx = w_sum[CW-1:0];
            w_state_nx  = ST_ACCUM;
          end
        end
      end

      ST_VEND: begin
        w_coin_reject_nx = w_coin_evt;
        if (bus.Vend_ack) begin
          w_vend_nx  = 1'b0;
          w_state_nx = w_credit_nz ? ST_CHANGE : ST_IDLE;
        end
      end

      ST_CHANGE, ST_REFUND: begin
        w_coin_reject_nx = w_coin_evt;
        if (w_credit_nz) begin
          w_change_pulse_nx = 1'b1;
          w_credit_nx       = r_credit - CREDIT_ONE;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end

      default: begin
        w_state_nx  = ST_IDLE;
        w_credit_nx = '0;
        w_vend_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CP_20ms) begin
    // pre_x follows the slot even through reset, so a coin held across a
    // service reset is only counted once it is withdrawn and re-inserted.
    r_pre_x <= bus.X;
    if (Rst_sync) begin
      r_state        <= ST_IDLE;
      r_credit       <= '0;
      r_vend         <= 1'b0;
      r_change_pulse <= 1'b0;
      r_coin_reject  <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_credit       <= w_credit_nx;
      r_vend         <= w_vend_nx;
      r_change_pulse <= w_change_pulse_nx;
      r_coin_reject  <= w_coin_reject_nx;
    end
  end

  assign bus.cur_state    = r_state;
  assign bus.Credit       = r_credit;
  assign bus.Vend         = r_vend;
  assign bus.Change_pulse = r_change_pulse;
  assign bus.Coin_reject  = r_coin_reject;
  assign bus.Busy         = (r_state == ST_VEND) || (r_state == ST_CHANGE) ||
                            (r_state == ST_REFUND);

endmodule
`default_nettype wire

// File: doc/drink_vending_ctrl.md
Name: drink_vending_ctrl

Overview:
Parametrised successor to the team's two-coin drink machine FSM. It accepts three coin denominations, counts each coin exactly once regardless of how many clocks it is held, and accumulates credit against a configurable price. When credit reaches the price it vends with a handshake, then pays change serially, one unit pulse per cycle; it also supports cancel/refund. It sits between the debounced coin-slot decoder and the dispenser/change-hopper drivers.

Parameters:
CW, 5, credit register width in units of 0.5 yuan; max credit 2^CW-1
PRICE, 3, product price in 0.5-yuan units (default 1.5 yuan); legal range 1..2^CW-1
V1, 1, value of coin code 01 (0.5 yuan)
V2, 2, value of coin code 10 (1 yuan)
V3, 10, value of coin code 11 (5 yuan); each Vn must be <= 2^CW-1

Ports:
CP_20ms  in  1  system clock, rising edge
Rst_sync  in  1  synchronous reset, active-high
X  in  2  coin code: 00 none, 01 V1, 10 V2, 11 V3; held for >=1 cycle per coin
Cancel  in  1  refund request, sampled every cycle
Vend_ack  in  1  dispenser accepted the vend
cur_state  out  3  current FSM state
Credit  out  CW  current credit / remaining change
Vend  out  1  dispense request, held high until acked
Change_pulse  out  1  one-cycle pulse = return one 0.5-yuan unit
Coin_reject  out  1  one-cycle pulse: the coin was not accepted (hopper returns it)
Busy  out  1  high in VEND, CHANGE, REFUND

Behaviour:
- Reset (Rst_high at edge): cur_state=IDLE, Credit=0, Vend=0, Change_pulse=0, Coin_reject=0, internal pre_X=00. Reset wins over every other event, in every state.
- pre_X is a register loaded with X every cycle, including reset-free non-accepting states.
- coin_evt = (X!=00) && (X!=pre_X). A held code gives exactly one event. A direct change between nonzero codes (e.g. 01->10) is a new event. coin_val is V1/V2/V3 per code; sum is computed in CW+1 bits.
- States (encoding): IDLE=000, ACCUM=001, VEND=010, CHANGE=011, REFUND=100. Codes 101/110/111 go to IDLE with Credit cleared on the next edge.
- IDLE/ACCUM, coin_evt, Cancel=0:
  - sum > 2^CW-1: reject. Coin_reject=1 next cycle; Credit and state unchanged.
  - sum >= PRICE: Credit<=sum-PRICE, Vend<=1, state<=VEND. This is a 1-cycle latency from the coin to Vend.
  - otherwise: Credit<=sum, state<=ACCUM.
- ACCUM, Cancel=1: state<=REFUND. A coin_evt in the same cycle is rejected (Coin_reject pulse); Cancel wins.
- IDLE, Cancel: ignored. A coincident coin is processed normally.
- VEND: Vend held at 1 until a cycle with Vend_ack=1. At that edge Vend<=0, and state<=CHANGE if Credit!=0, else IDLE. Cancel is ignored.
- CHANGE/REFUND: every cycle with Credit!=0, Change_pulse=1 and Credit decrements by 1. Pulses appear on consecutive cycles, and exactly the entry Credit pulses are issued. The edge after the last pulse (Credit==0) goes to IDLE. REFUND entered with Credit already 0 is not reachable, because ACCUM implies Credit>0.
- Any coin_evt in VEND/CHANGE/REFUND: Coin_reject pulse next cycle, credit unaffected. pre_X still tracks, so a held coin is not counted after returning to IDLE.
- Coin_reject and Change_pulse are registered, single-cycle pulses. Vend is a registered level.
- Busy = (cur_state is VEND, CHANGE or REFUND), combinational from cur_state.
- Rst mid-CHANGE: the remaining change is forfeited and Credit=0. This is intended; it is the operator service reset.

Test Plan:
- Defaults; X=01 for 3 cycles, then 00, then X=10 for 2 cycles -> Credit=1 after the first coin (counted once). Vend=1 one cycle after the 10 event, Credit=0. Vend_ack -> IDLE, no Change_pulse.
- X=11 (5 yuan) from IDLE -> VEND with Credit=7. After Vend_ack, 7 consecutive Change_pulse cycles, Credit counts 7..0, then IDLE. A coin inserted during CHANGE -> Coin_reject pulse, count unaffected.
- X=01, X=00, Cancel=1 -> REFUND, 1 Change_pulse, IDLE. Cancel and X=10 in the same ACCUM cycle -> Coin_reject=1, refund of the prior credit only.
- Override CW=4, PRICE=15; X=11 then 00 then 11 -> Credit=10; the second coin is rejected (20>15), Credit stays 10, state stays ACCUM.
- Vend_ack held low for 50 cycles -> Vend stays 1, Cancel ignored, state VEND. Then assert ack -> correct exit.
- Rst_sync=1 for one edge mid-CHANGE (Credit=4) -> next cycle IDLE, Credit=0, all outputs 0. An X held across the reset is not counted until it returns to 00 and is re-inserted.
